alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Registered result queue sitting directly downstream of the 64-bit ALU datapath units (rotate, shift, add/sub), capturing their 64-bit result buses with a valid/ready handshake. It decouples combinational ALU evaluation from the writeback stage and holds up to DEPTH results in arrival order. Optionally it annotates each entry with status flags computed at capture time.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- TAG_W, 4, width of the op/destination tag carried alongside each result.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising edge.
- in_valid  input  1  ALU result present this cycle.
- in_ready  output  1  buffer can accept; high when count < DEPTH.
- in_result  input  64  ALU result; rotate/shift units drive [63:32] = 0.
- in_tag  input  TAG_W  op/destination tag.
- out_valid  output  1  head entry available; high when count != 0.
- out_ready  input  1  writeback consumes head this cycle.
- out_result  output  64  head result; 0 when out_valid low.
- out_tag  output  TAG_W  head tag; 0 when out_valid low.
- out_zero  output  1  head result == 64'h0.
- out_neg  output  1  head result bit 31.
- out_hi_nz  output  1  head result [63:32] != 0.
- count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular array of DEPTH entries {result, tag, flags}; write pointer wp, read pointer rp, each $clog2(DEPTH) bits, wrap modulo DEPTH; occupancy counter count.
- Push: in_valid && in_ready → entry[wp] ← {in_result, in_tag, flags}, wp ← wp+1.
- Pop: out_valid && out_ready → rp ← rp+1.
- count: +1 on push-only, −1 on pop-only, unchanged on push+pop or neither.
- Flags are computed from in_result at push time and stored; outputs present the stored values.
- in_ready depends only on count (not on out_ready): when full, a same-cycle pop does not admit a push.
- When empty, no bypass: a push is not visible at the output in the same cycle.
- in_valid while in_ready low: ignored, no state change; upstream holds its data.
- out_result/out_tag/out_* flags are forced to 0 whenever out_valid is low.
- Storage contents are not reset; only pointers and count are cleared.
- Reset mid-operation: all queued entries discarded; reset has priority over any same-cycle push/pop.

## Timing
- Reset values: in_ready=1, out_valid=0, count=0, out_result=0, out_tag=0, out_zero=0, out_neg=0, out_hi_nz=0.
- Latency: push accepted on edge N → out_valid and data at head visible after edge N (cycle N+1), when the buffer was empty.
- Throughput: one push and one pop per cycle sustained whenever 0 < count < DEPTH.
- in_ready, out_valid and count are pure functions of registered state (no combinational input-to-output paths).
- Wrap: pointers roll from DEPTH−1 to 0 without bubble.

## Configuration
- ALU_RESBUF_FLAGS_EN defined: flag bits are computed, stored per entry (3 extra bits per entry), and driven on out_zero/out_neg/out_hi_nz as above.
- Undefined: no flag storage or logic; out_zero, out_neg, out_hi_nz are constant 0. Handshake, data and timing otherwise identical.

## Test plan
- Reset then idle: after reset, in_ready=1, out_valid=0, count=0, out_result=0 for 10 cycles with in_valid=0.
- Fill/drain (DEPTH=4): push 64'h1, 2, 3, 4 with out_ready=0 → count=4, in_ready=0; 5th push 64'h5 ignored; drain with out_ready=1 → outputs 1,2,3,4 in order, then out_valid=0.
- Full, simultaneous push+pop: count=4, in_valid=1, out_ready=1 → pop occurs, push rejected, count=3 next cycle.
- Streaming wrap: 20 consecutive pushes with out_ready=1 → count stays ≤1, outputs match inputs and tags in order, pointers wrap with no gap.
- Flags (ALU_RESBUF_FLAGS_EN): push 64'h0 → zero=1; 64'h0000_0000_8000_0000 → neg=1, hi_nz=0; 64'h0000_0001_0000_0000 → hi_nz=1, zero=0; without macro all three flags read 0.
- Reset mid-operation: count=3, assert reset with in_valid=1, out_ready=1 → next cycle count=0, out_valid=0, in_ready=1, pushed data not retained.

Source files
------------

// File: rtl/alu_result_buffer.sv
// rtl/alu_result_buffer.sv - registered FIFO of 64-bit ALU results with tags, between the ALU and writeback
// Defining ALU_RESBUF_FLAGS_EN stores zero/neg/hi_nz flags per entry; without it the three flag outputs are tied to 0.
module alu_result_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [63:0]              in_result,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_zero,
  output logic                     out_neg,
  output logic                     out_hi_nz,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push, pop;

  logic [63:0]      result_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q    [DEPTH];

  // Handshake status comes from registered occupancy only, so a pop cannot free a slot for a same-cycle push.
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    if (push) wp_d = wp_q + PTR_W'(1);
    if (pop)  rp_d = rp_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left unreset; stale contents are masked by out_valid.
  always_ff @(posedge clock) begin
    if (push) begin
      result_mem_q[wp_q] <= in_result;
      tag_mem_q[wp_q]    <= in_tag;
    end
  end

  assign count = count_q;

  always_comb begin
    out_result = '0;
    out_tag    = '0;
    if (out_valid) begin
      out_result = result_mem_q[rp_q];
      out_tag    = tag_mem_q[rp_q];
    end
  end

`ifdef ALU_RESBUF_FLAGS_EN
  logic [2:0] flag_mem_q [DEPTH];
  logic [2:0] in_flags;

  // Flag order: {zero, neg (bit 31), hi_nz}; computed once at capture time.
  always_comb begin
    in_flags = {(in_result == 64'h0), in_result[31], (|in_result[63:32])};
  end

  always_ff @(posedge clock) begin
    if (push) flag_mem_q[wp_q] <= in_flags;
  end

  always_comb begin
    out_zero  = 1'b0;
    out_neg   = 1'b0;
    out_hi_nz = 1'b0;
    if (out_valid) begin
      out_zero  = flag_mem_q[rp_q][2];
      out_neg   = flag_mem_q[rp_q][1];
      out_hi_nz = flag_mem_q[rp_q][0];
    end
  end
`else
  assign out_zero  = 1'b0;
  assign out_neg   = 1'b0;
  assign out_hi_nz = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// tb/tb_alu_result_buffer.sv - randomized self-checking bench for alu_result_buffer against a queue model
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_result;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_neg;
  logic             out_hi_nz;
  logic [CNT_W-1:0] count;

  typedef struct packed {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t model_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_result_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_hi_nz  (out_hi_nz),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [63:0]      h;
    logic [TAG_W-1:0] t;
    logic             v;
    v = (model_q.size() != 0);
    h = v ? model_q[0].res : 64'h0;
    t = v ? model_q[0].tag : '0;
    chk("in_ready",   64'(in_ready),   64'(model_q.size() < DEPTH));
    chk("out_valid",  64'(out_valid),  64'(v));
    chk("count",      64'(count),      64'(model_q.size()));
    chk("out_result", out_result,      h);
    chk("out_tag",    64'(out_tag),    64'(t));
`ifdef ALU_RESBUF_FLAGS_EN
    chk("out_zero",   64'(out_zero),   64'(v && (h == 64'h0)));
    chk("out_neg",    64'(out_neg),    64'(v && h[31]));
    chk("out_hi_nz",  64'(out_hi_nz),  64'(v && (h[63:32] != 32'h0)));
`else
    chk("out_zero",   64'(out_zero),   64'h0);
    chk("out_neg",    64'(out_neg),    64'h0);
    chk("out_hi_nz",  64'(out_hi_nz),  64'h0);
`endif
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the model at the rising edge.
  task automatic cycle(input logic rst, input logic v, input logic r,
                       input logic [63:0] res, input logic [TAG_W-1:0] tg);
    logic do_push, do_pop;
    ent_t e;
    @(negedge clock);
    reset     = rst;
    in_valid  = v;
    out_ready = r;
    in_result = res;
    in_tag    = tg;
    #1 check_outputs();
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    @(posedge clock);
    if (rst) begin
      model_q.delete();
    end else begin
      if (do_pop) void'(model_q.pop_front());
      if (do_push) begin
        e.res = res;
        e.tag = tg;
        model_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 64'h0, '0);
  endtask

  logic [63:0] rnd;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_result = '0;
    in_tag    = '0;
    repeat (2) @(posedge clock);
    model_q.delete();

    // Reset then idle
    cycle(1'b0, 1'b0, 1'b0, 64'h0, '0);
    idle(10);

    // Fill, rejected fifth push, drain in order
    for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'(i), TAG_W'(i));
    cycle(1'b0, 1'b1, 1'b0, 64'h5, TAG_W'(5));
    chk("full_count", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0, '0);
    idle(2);

    // Full with simultaneous push and pop
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 64'h100 + 64'(i), TAG_W'(i));
    cycle(1'b0, 1'b1, 1'b1, 64'hdead, TAG_W'(9));
    idle(1);
    chk("full_pushpop_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0, '0);

    // Streaming wrap
    for (int i = 0; i < 20; i++) begin
      rnd = {$urandom, $urandom};
      cycle(1'b0, 1'b1, 1'b1, rnd, TAG_W'($urandom));
      chk("stream_count_le1", 64'(count <= 1), 64'h1);
    end
    idle(2);

    // Flag patterns
    cycle(1'b0, 1'b1, 1'b0, 64'h0, TAG_W'(1));
    cycle(1'b0, 1'b1, 1'b0, 64'h0000_0000_8000_0000, TAG_W'(2));
    cycle(1'b0, 1'b1, 1'b0, 64'h0000_0001_0000_0000, TAG_W'(3));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 64'h0, '0);
    idle(1);

    // Reset mid-operation with push and pop asserted
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 64'h200 + 64'(i), TAG_W'(i));
    cycle(1'b1, 1'b1, 1'b1, 64'hbeef, TAG_W'(7));
    idle(1);
    chk("post_reset_count", 64'(count), 64'h0);

    // Random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rnd = 64'h0;
        1:       rnd = {32'h0, $urandom};
        default: rnd = {$urandom, $urandom};
      endcase
      cycle(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 2) != 0, rnd, TAG_W'($urandom));
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
